// File: rtl/biriscv_fetch_buffer.sv
// ----------------------------------------------------------------------------
// biriscv_fetch_buffer
//
// Instruction queue between the fetch unit and the dual-issue decoders.
// Each entry holds one 64-bit fetch packet (two instruction slots), its
// 8-byte aligned PC, fault flags and a 2-bit mask of slots not yet issued.
// The head entry is presented combinationally as up to two in-order slots.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   fetch_valid_i           packet valid from fetch
//   fetch_instr_i[63:0]     packet ([31:0] at PC&~7, [63:32] at (PC&~7)+4)
//   fetch_pc_i[31:0]        packet PC (bit 2 set: upper slot only)
//   fetch_fault_fetch_i     bus error on this fetch
//   fetch_fault_page_i      page fault on this fetch
//   fetch_accept_o          buffer can take a packet this cycle
//   squash_i                flush everything (redirect)
//   slotN_valid_o           slot N presented
//   slotN_instr_o/_pc_o     instruction and its PC (0 when invalid)
//   slotN_fault_*_o         fault flags (only ever set on slot 0)
//   slotN_accept_i          issue consumed slot N this cycle
// ----------------------------------------------------------------------------
module biriscv_fetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    input  logic [63:0] fetch_instr_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_fault_fetch_i,
    input  logic        fetch_fault_page_i,
    output logic        fetch_accept_o,
    input  logic        squash_i,
    output logic        slot0_valid_o,
    output logic [31:0] slot0_instr_o,
    output logic [31:0] slot0_pc_o,
    output logic        slot0_fault_fetch_o,
    output logic        slot0_fault_page_o,
    input  logic        slot0_accept_i,
    output logic        slot1_valid_o,
    output logic [31:0] slot1_instr_o,
    output logic [31:0] slot1_pc_o,
    output logic        slot1_fault_fetch_o,
    output logic        slot1_fault_page_o,
    input  logic        slot1_accept_i
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [63:0]      instr_reg       [DEPTH];
    logic [28:0]      pc_reg          [DEPTH];
    logic             fault_fetch_reg [DEPTH];
    logic             fault_page_reg  [DEPTH];
    logic [1:0]       mask_reg        [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic [1:0]       head_mask;
    logic [1:0]       head_mask_next;
    logic [1:0]       push_mask;
    logic             push;
    logic             pop;
    logic             slot0_fire;
    logic             slot1_fire;
    logic             push_fault;

    // The two low PC bits carry no information for a 32-bit instruction stream
    logic unused_pc_bits;
    assign unused_pc_bits = ^fetch_pc_i[1:0];

    // Full-only backpressure keeps the accepts off the fetch_accept_o path
    assign fetch_accept_o = (count_reg != CNT_W'(DEPTH));

    assign push       = fetch_valid_i & fetch_accept_o & ~squash_i;
    assign push_fault = fetch_fault_fetch_i | fetch_fault_page_i;

    // A fault packet exposes a single slot so the fault is reported once
    always_comb begin
        push_mask = 2'b11;
        if (fetch_pc_i[2])
            push_mask = 2'b10;
        else if (push_fault)
            push_mask = 2'b01;
    end

    assign head_mask = mask_reg[rd_ptr_reg];

    // Head presentation
    always_comb begin
        slot0_valid_o       = 1'b0;
        slot0_instr_o       = 32'd0;
        slot0_pc_o          = 32'd0;
        slot0_fault_fetch_o = 1'b0;
        slot0_fault_page_o  = 1'b0;
        slot1_valid_o       = 1'b0;
        slot1_instr_o       = 32'd0;
        slot1_pc_o          = 32'd0;
        slot1_fault_fetch_o = 1'b0;
        slot1_fault_page_o  = 1'b0;
        if (count_reg != '0) begin
            case (head_mask)
                2'b11: begin
                    slot0_valid_o = 1'b1;
                    slot0_instr_o = instr_reg[rd_ptr_reg][31:0];
                    slot0_pc_o    = {pc_reg[rd_ptr_reg], 3'b000};
                    slot1_valid_o = 1'b1;
                    slot1_instr_o = instr_reg[rd_ptr_reg][63:32];
                    slot1_pc_o    = {pc_reg[rd_ptr_reg], 3'b100};
                end
                2'b10: begin
                    slot0_valid_o = 1'b1;
                    slot0_instr_o = instr_reg[rd_ptr_reg][63:32];
                    slot0_pc_o    = {pc_reg[rd_ptr_reg], 3'b100};
                end
                2'b01: begin
                    slot0_valid_o = 1'b1;
                    slot0_instr_o = instr_reg[rd_ptr_reg][31:0];
                    slot0_pc_o    = {pc_reg[rd_ptr_reg], 3'b000};
                end
                default: ;
            endcase
            slot0_fault_fetch_o = slot0_valid_o & fault_fetch_reg[rd_ptr_reg];
            slot0_fault_page_o  = slot0_valid_o & fault_page_reg[rd_ptr_reg];
        end
    end

    // Slot 1 can only be taken together with slot 0 (in-order issue)
    assign slot0_fire = slot0_valid_o & slot0_accept_i;
    assign slot1_fire = slot0_fire & slot1_valid_o & slot1_accept_i;

    always_comb begin
        head_mask_next = head_mask;
        if (slot1_fire)
            head_mask_next = 2'b00;
        else if (slot0_fire)
            head_mask_next = (head_mask == 2'b11) ? 2'b10 : 2'b00;
    end

    assign pop = slot0_fire & (head_mask_next == 2'b00);

    // Per-entry storage
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    instr_reg[gi]       <= 64'd0;
                    pc_reg[gi]          <= 29'd0;
                    fault_fetch_reg[gi] <= 1'b0;
                    fault_page_reg[gi]  <= 1'b0;
                    mask_reg[gi]        <= 2'b00;
                end else if (squash_i) begin
                    mask_reg[gi]        <= 2'b00;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    // Write slot never equals a non-empty head, so no clash
                    instr_reg[gi]       <= push_fault ? 64'd0 : fetch_instr_i;
                    pc_reg[gi]          <= fetch_pc_i[31:3];
                    fault_fetch_reg[gi] <= fetch_fault_fetch_i;
                    fault_page_reg[gi]  <= fetch_fault_page_i;
                    mask_reg[gi]        <= push_mask;
                end else if (slot0_fire && (rd_ptr_reg == PTR_W'(gi))) begin
                    mask_reg[gi]        <= head_mask_next;
                end
            end
        end
    endgenerate

    // Pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i || squash_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_biriscv_fetch_buffer.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for biriscv_fetch_buffer (DEPTH = 2).
// Inputs change 1 ns after the rising edge; outputs are checked in the same
// window, before the next rising edge.
// ----------------------------------------------------------------------------
module tb_biriscv_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [63:0] fetch_instr = 64'd0;
    logic [31:0] fetch_pc = 32'd0;
    logic        fault_fetch = 1'b0;
    logic        fault_page = 1'b0;
    logic        fetch_accept;
    logic        squash = 1'b0;
    logic        s0_valid, s1_valid;
    logic [31:0] s0_instr, s1_instr, s0_pc, s1_pc;
    logic        s0_ff, s0_fp, s1_ff, s1_fp;
    logic        s0_accept = 1'b0;
    logic        s1_accept = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    biriscv_fetch_buffer #(.DEPTH(2)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .fetch_valid_i      (fetch_valid),
        .fetch_instr_i      (fetch_instr),
        .fetch_pc_i         (fetch_pc),
        .fetch_fault_fetch_i(fault_fetch),
        .fetch_fault_page_i (fault_page),
        .fetch_accept_o     (fetch_accept),
        .squash_i           (squash),
        .slot0_valid_o      (s0_valid),
        .slot0_instr_o      (s0_instr),
        .slot0_pc_o         (s0_pc),
        .slot0_fault_fetch_o(s0_ff),
        .slot0_fault_page_o (s0_fp),
        .slot0_accept_i     (s0_accept),
        .slot1_valid_o      (s1_valid),
        .slot1_instr_o      (s1_instr),
        .slot1_pc_o         (s1_pc),
        .slot1_fault_fetch_o(s1_ff),
        .slot1_fault_page_o (s1_fp),
        .slot1_accept_i     (s1_accept)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [63:0] instr);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_instr = instr;
    endtask

    task automatic idle();
        fetch_valid = 1'b0;
        s0_accept   = 1'b0;
        s1_accept   = 1'b0;
        squash      = 1'b0;
        fault_fetch = 1'b0;
        fault_page  = 1'b0;
    endtask

    initial begin
        // Reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_accept", 32'(fetch_accept), 32'd1);
        chk("rst_s0v",    32'(s0_valid), 32'd0);
        chk("rst_s1v",    32'(s1_valid), 32'd0);
        chk("rst_s0i",    s0_instr, 32'd0);
        chk("rst_s0pc",   s0_pc, 32'd0);
        $display("txn reset done");

        // Aligned packet, both slots consumed
        push(32'h1000, {32'h00208093, 32'h00100093});
        tick(); idle();
        chk("al_s0v",  32'(s0_valid), 32'd1);
        chk("al_s0i",  s0_instr, 32'h00100093);
        chk("al_s0pc", s0_pc, 32'h1000);
        chk("al_s1v",  32'(s1_valid), 32'd1);
        chk("al_s1i",  s1_instr, 32'h00208093);
        chk("al_s1pc", s1_pc, 32'h1004);
        s0_accept = 1'b1; s1_accept = 1'b1;
        tick(); idle();
        chk("al_pop_s0v", 32'(s0_valid), 32'd0);
        chk("al_pop_acc", 32'(fetch_accept), 32'd1);
        $display("txn aligned pc=00001000");

        // Misaligned entry: only the upper word
        push(32'h2004, {32'h11111111, 32'h22222222});
        tick(); idle();
        chk("mis_s0v",  32'(s0_valid), 32'd1);
        chk("mis_s0i",  s0_instr, 32'h11111111);
        chk("mis_s0pc", s0_pc, 32'h2004);
        chk("mis_s1v",  32'(s1_valid), 32'd0);
        chk("mis_s1i",  s1_instr, 32'd0);
        s0_accept = 1'b1;
        tick(); idle();
        chk("mis_pop", 32'(s0_valid), 32'd0);
        $display("txn misaligned pc=00002004");

        // Partial consume; slot1 accept alone is ignored
        push(32'h3000, {32'h33330004, 32'h33330000});
        tick(); idle();
        s1_accept = 1'b1;
        tick(); idle();
        chk("s1only_s0i", s0_instr, 32'h33330000);
        chk("s1only_s1v", 32'(s1_valid), 32'd1);
        s0_accept = 1'b1;
        tick(); idle();
        chk("part_s0v",  32'(s0_valid), 32'd1);
        chk("part_s0i",  s0_instr, 32'h33330004);
        chk("part_s0pc", s0_pc, 32'h3004);
        chk("part_s1v",  32'(s1_valid), 32'd0);
        s0_accept = 1'b1;
        tick(); idle();
        chk("part_pop", 32'(s0_valid), 32'd0);
        $display("txn partial pc=00003000");

        // Full / backpressure
        push(32'h5000, {32'h50000001, 32'h50000000});
        tick();
        chk("full_acc1", 32'(fetch_accept), 32'd1);
        push(32'h5008, {32'h50080001, 32'h50080000});
        tick();
        chk("full_acc2", 32'(fetch_accept), 32'd0);
        push(32'h5010, {32'h50100001, 32'h50100000});
        tick(); idle();
        chk("full_acc3",  32'(fetch_accept), 32'd0);
        chk("full_head",  s0_pc, 32'h5000);
        s0_accept = 1'b1; s1_accept = 1'b1;
        tick(); idle();
        chk("full_rise",  32'(fetch_accept), 32'd1);
        chk("full_next",  s0_pc, 32'h5008);
        chk("full_nexti", s0_instr, 32'h50080000);
        s0_accept = 1'b1; s1_accept = 1'b1;
        tick(); idle();
        chk("full_drop3", 32'(s0_valid), 32'd0);
        $display("txn backpressure third packet dropped");

        // Streaming 10 packets through the 2-deep buffer with pointer wrap
        for (int k = 0; k <= 10; k++) begin
            if (k < 10)
                push(32'h6000 + 32'(k * 8), {32'hB000_0000 + 32'(k), 32'hA000_0000 + 32'(k)});
            else
                fetch_valid = 1'b0;
            if (k > 0) begin
                chk("strm_s0pc", s0_pc, 32'h6000 + 32'((k - 1) * 8));
                chk("strm_s0i",  s0_instr, 32'hA000_0000 + 32'(k - 1));
                chk("strm_s1i",  s1_instr, 32'hB000_0000 + 32'(k - 1));
                chk("strm_acc",  32'(fetch_accept), 32'd1);
                $display("txn stream pkt=%0d pc=%h", k - 1, s0_pc);
            end
            s0_accept = 1'b1; s1_accept = 1'b1;
            tick();
        end
        idle();
        chk("strm_empty", 32'(s0_valid), 32'd0);

        // Fault packet
        push(32'h4000, 64'hDEADBEEF_CAFEF00D);
        fault_page = 1'b1;
        tick(); idle();
        chk("flt_s0v",  32'(s0_valid), 32'd1);
        chk("flt_s0i",  s0_instr, 32'd0);
        chk("flt_s0pc", s0_pc, 32'h4000);
        chk("flt_fp",   32'(s0_fp), 32'd1);
        chk("flt_ff",   32'(s0_ff), 32'd0);
        chk("flt_s1v",  32'(s1_valid), 32'd0);
        s0_accept = 1'b1;
        tick(); idle();
        chk("flt_pop", 32'(s0_valid), 32'd0);
        $display("txn fault pc=00004000");

        // Squash with two entries queued, a push and an accept
        push(32'h7000, {32'h70000001, 32'h70000000});
        tick();
        push(32'h7008, {32'h70080001, 32'h70080000});
        tick();
        push(32'h7010, {32'h70100001, 32'h70100000});
        squash = 1'b1; s0_accept = 1'b1;
        tick(); idle();
        chk("sq_s0v", 32'(s0_valid), 32'd0);
        chk("sq_s1v", 32'(s1_valid), 32'd0);
        chk("sq_acc", 32'(fetch_accept), 32'd1);
        // Squash where the push would otherwise have been accepted
        push(32'h7100, {32'h71000001, 32'h71000000});
        tick();
        push(32'h7108, {32'h71080001, 32'h71080000});
        squash = 1'b1; s0_accept = 1'b1;
        tick(); idle();
        chk("sq2_s0v", 32'(s0_valid), 32'd0);
        push(32'h8000, {32'h80000001, 32'h80000000});
        tick(); idle();
        chk("sq_next_pc",  s0_pc, 32'h8000);
        chk("sq_next_i",   s0_instr, 32'h80000000);
        chk("sq_next_s1",  s1_pc, 32'h8004);
        $display("txn squash then pc=00008000");

        // Reset mid-stream
        push(32'h9000, {32'h90000001, 32'h90000000});
        tick(); idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_s0v", 32'(s0_valid), 32'd0);
        chk("mrst_acc", 32'(fetch_accept), 32'd1);
        chk("mrst_s0i", s0_instr, 32'd0);
        $display("txn midstream reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/biriscv_fetch_buffer.md
# biriscv_fetch_buffer

Instruction buffer between the frontend fetch unit and the instruction decoders. Accepts 64-bit fetch packets (two 32-bit instruction slots) with PC and fault status, queues them in a small FIFO, and presents up to two instructions per cycle, in program order, to the dual-issue decode/issue stage. Handles misaligned packet entry (PC bit 2 set), partial consumption of a packet, fault packets and pipeline flush.

## Interface
- DEPTH, 2, number of packet entries; power of two, at least 2.
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- fetch_valid_i  in  1  packet valid.
- fetch_instr_i  in  64  packet; [31:0] = instruction at PC & ~7, [63:32] = instruction at (PC & ~7) + 4.
- fetch_pc_i  in  32  packet PC; bit 2 set means only the upper slot is valid.
- fetch_fault_fetch_i  in  1  bus error on fetch.
- fetch_fault_page_i  in  1  page fault on fetch.
- fetch_accept_o  out  1  buffer can take a packet this cycle.
- squash_i  in  1  flush (branch or exception redirect).
- slot0_valid_o / slot1_valid_o  out  1  slot presented.
- slot0_instr_o / slot1_instr_o  out  32  instruction.
- slot0_pc_o / slot1_pc_o  out  32  instruction PC.
- slot0_fault_fetch_o, slot0_fault_page_o, slot1_fault_fetch_o, slot1_fault_page_o  out  1  fault flags, drive the decoders' fetch_fault input.
- slot0_accept_i / slot1_accept_i  in  1  issue consumed the slot this cycle.

## Operation
- Storage: DEPTH entries of {instr[63:0], pc[31:3], fault_fetch, fault_page, mask[1:0]}, plus read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of 0..DEPTH.
- Push on fetch_valid_i & fetch_accept_o & ~squash_i. The mask is set to 2'b10 if pc[2]=1, else 2'b11. If either fault flag is set, the mask is forced to 2'b01 when pc[2]=0 and 2'b10 otherwise, so only one slot carries the fault. A fault entry's instruction word is stored as all zeros.
- fetch_accept_o = (count != DEPTH). It does not depend on pops in the same cycle.
- Presentation comes from the head entry only, and is combinational from registered state:
  - mask 11: slot0 = lower word, PC {pc,3'b000}; slot1 = upper word, PC {pc,3'b100}.
  - mask 10: slot0 = upper word, PC {pc,3'b100}; slot1 invalid.
  - mask 01: slot0 = lower word; slot1 invalid.
  - count 0: both slots invalid.
- Fault flags are presented on slot0 only, and only for fault entries.
- An invalid slot drives instr, pc and faults as 0.
- Consumption:
  - slot1_accept_i is honoured only when slot0_accept_i is high and slot1_valid_o is high. An accept on an invalid slot is ignored.
  - Accepting slot0 alone on mask 11 sets the mask to 10, so the upper word moves to slot0 next cycle.
  - When the remaining mask reaches 00, the entry is popped and the read pointer advances.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- squash_i: next cycle count = 0, pointers = 0, all masks = 00. A push and any accepts in the same cycle are discarded. squash_i has priority over everything except rst_i.
- Reset: count, pointers, masks and stored data are cleared. After reset all outputs are 0 except fetch_accept_o = 1.

## Timing
- A packet pushed in cycle N is visible on the slots in cycle N+1, i.e. 1 cycle latency.
- There is no combinational path from fetch_valid_i to the slot outputs.
- There is no combinational path from slot accepts to fetch_accept_o.
- Throughput is one packet per cycle when issue takes both slots every cycle. A buffer with DEPTH=2 sustains this without bubbles.
- squash_i asserted in cycle N gives empty slots and fetch_accept_o = 1 in cycle N+1.
- rst_i asserted mid-stream behaves the same as squash and also clears data.

## Test plan
- Aligned stream:
  - Stimulus: push PC 0x1000, instr {0x00208093, 0x00100093}; accept both.
  - Required: next cycle slot0 = 0x00100093 @0x1000 and slot1 = 0x00208093 @0x1004; the entry pops; count returns to 0.
- Misaligned entry:
  - Stimulus: push PC 0x2004.
  - Required: only slot0 valid, showing the upper word @0x2004; slot1_valid_o = 0; a single slot0 accept pops the entry.
- Partial consume:
  - Stimulus: mask-11 entry at 0x3000; accept slot0 only.
  - Required: next cycle slot0 shows the upper word @0x3004 and slot1 is invalid; a second accept pops the entry.
  - Also: slot1_accept_i asserted without slot0_accept_i is ignored.
- Full / backpressure:
  - Stimulus: DEPTH=2; push 3 packets with no accepts.
  - Required: fetch_accept_o drops after the 2nd push; the 3rd packet is not stored; after both slots are accepted, accept rises next cycle and FIFO order is preserved across pointer wrap over 10 packets.
- Fault packet:
  - Stimulus: push PC 0x4000 with fetch_fault_page_i = 1.
  - Required: slot0 valid, instr 0, pc 0x4000, slot0_fault_page_o = 1; slot1 invalid.
- Squash collision:
  - Stimulus: two entries queued; assert squash_i together with a push and a slot0 accept.
  - Required: next cycle both slots invalid, fetch_accept_o = 1; the pushed packet is lost; the following push at 0x8000 appears as the next slot0.
